// File: rtl/mpu_reg_arbiter.sv
// mpu_reg_arbiter: round-robin, transaction-locked arbiter for the matrix register file
// write port (load/collector) and read port (store/dispatcher) with cross-port hazard blocking.
module mpu_reg_arbiter #(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_req,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              coll_req,
   input  logic [ADDR_W-1:0] coll_addr,
   input  logic              store_req,
   input  logic [ADDR_W-1:0] store_addr,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr0,
   input  logic [ADDR_W-1:0] disp_addr1,
   output logic              load_gnt,
   output logic              coll_gnt,
   output logic              store_gnt,
   output logic              disp_gnt,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              hazard_stall
);
   typedef enum logic [1:0] {W_IDLE, W_LOAD, W_COLL} wr_st_t;
   typedef enum logic [1:0] {R_IDLE, R_STORE, R_DISP} rd_st_t;

   wr_st_t            wr_st_q, wr_st_d;
   rd_st_t            rd_st_q, rd_st_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] rd_a0_q, rd_a0_d, rd_a1_q, rd_a1_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;

   logic wr_busy, rd_busy, rd_new, rd_live;
   logic store_haz, disp_haz, load_haz, coll_haz;
   logic store_ok, disp_ok, load_ok, coll_ok;
   logic rd_pick_store, rd_pick_disp, wr_pick_load, wr_pick_coll;
   logic [ADDR_W-1:0] rd_c0, rd_c1;

   assign wr_busy   = wr_st_q != W_IDLE;
   assign rd_busy   = rd_st_q != R_IDLE;
   assign store_haz = wr_busy && store_addr == wr_addr_q;
   assign disp_haz  = wr_busy && (disp_addr0 == wr_addr_q || disp_addr1 == wr_addr_q);
   assign store_ok  = store_req && !store_haz;
   assign disp_ok   = disp_req && !disp_haz;
   // rd_ptr_q=1 gives store priority, 0 gives dispatcher priority
   assign rd_pick_store = store_ok && (!disp_ok || rd_ptr_q);
   assign rd_pick_disp  = disp_ok && !rd_pick_store;
   assign rd_new  = !rd_busy && (store_ok || disp_ok);
   assign rd_live = rd_busy || rd_new;
   // A read granted this very cycle also blocks a same-address write
   assign rd_c0 = rd_busy ? rd_a0_q : (rd_pick_store ? store_addr : disp_addr0);
   assign rd_c1 = rd_busy ? rd_a1_q : (rd_pick_store ? store_addr : disp_addr1);
   assign load_haz = rd_live && (load_addr == rd_c0 || load_addr == rd_c1);
   assign coll_haz = rd_live && (coll_addr == rd_c0 || coll_addr == rd_c1);
   assign load_ok  = load_req && !load_haz;
   assign coll_ok  = coll_req && !coll_haz;
   assign wr_pick_load = load_ok && (!coll_ok || !wr_ptr_q);
   assign wr_pick_coll = coll_ok && !wr_pick_load;

   always_comb begin
      wr_st_d   = wr_st_q;
      wr_addr_d = wr_addr_q;
      wr_ptr_d  = wr_ptr_q;
      case (wr_st_q)
         W_IDLE: if (wr_pick_load) begin
            wr_st_d   = W_LOAD;
            wr_addr_d = load_addr;
            wr_ptr_d  = 1'b1;
         end else if (wr_pick_coll) begin
            wr_st_d   = W_COLL;
            wr_addr_d = coll_addr;
            wr_ptr_d  = 1'b0;
         end
         W_LOAD: if (!load_req) begin
            wr_st_d   = W_IDLE;
            wr_addr_d = '0;
         end
         W_COLL: if (!coll_req) begin
            wr_st_d   = W_IDLE;
            wr_addr_d = '0;
         end
         default: begin
            wr_st_d   = W_IDLE;
            wr_addr_d = '0;
         end
      endcase
   end

   always_comb begin
      rd_st_d  = rd_st_q;
      rd_a0_d  = rd_a0_q;
      rd_a1_d  = rd_a1_q;
      rd_ptr_d = rd_ptr_q;
      case (rd_st_q)
         R_IDLE: if (rd_pick_store) begin
            rd_st_d  = R_STORE;
            rd_a0_d  = store_addr;
            rd_a1_d  = store_addr;
            rd_ptr_d = 1'b0;
         end else if (rd_pick_disp) begin
            rd_st_d  = R_DISP;
            rd_a0_d  = disp_addr0;
            rd_a1_d  = disp_addr1;
            rd_ptr_d = 1'b1;
         end
         R_STORE: rd_st_d = store_req ? R_STORE : R_IDLE;
         R_DISP:  rd_st_d = disp_req ? R_DISP : R_IDLE;
         default: rd_st_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_st_q   <= W_IDLE;
         rd_st_q   <= R_IDLE;
         wr_addr_q <= '0;
         rd_a0_q   <= '0;
         rd_a1_q   <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
      end else begin
         wr_st_q   <= wr_st_d;
         rd_st_q   <= rd_st_d;
         wr_addr_q <= wr_addr_d;
         rd_a0_q   <= rd_a0_d;
         rd_a1_q   <= rd_a1_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   assign load_gnt     = wr_st_q == W_LOAD;
   assign coll_gnt     = wr_st_q == W_COLL;
   assign store_gnt    = rd_st_q == R_STORE;
   assign disp_gnt     = rd_st_q == R_DISP;
   assign wr_addr      = wr_addr_q;
   assign hazard_stall = (!wr_busy && ((load_req && load_haz) || (coll_req && coll_haz))) ||
                         (!rd_busy && ((store_req && store_haz) || (disp_req && disp_haz)));
endmodule

// File: tb/tb_mpu_reg_arbiter.sv
// tb_mpu_reg_arbiter: directed vectors for mpu_reg_arbiter with hand-computed expectations.
module tb_mpu_reg_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic       load_req, coll_req, store_req, disp_req;
   logic [2:0] load_addr, coll_addr, store_addr, disp_addr0, disp_addr1;
   logic       load_gnt, coll_gnt, store_gnt, disp_gnt, hazard_stall;
   logic [2:0] wr_addr;
   int         n_chk = 0;
   int         n_err = 0;

   mpu_reg_arbiter #(.ADDR_W(3)) dut (
      .clk(clk), .rst(rst),
      .load_req(load_req), .load_addr(load_addr),
      .coll_req(coll_req), .coll_addr(coll_addr),
      .store_req(store_req), .store_addr(store_addr),
      .disp_req(disp_req), .disp_addr0(disp_addr0), .disp_addr1(disp_addr1),
      .load_gnt(load_gnt), .coll_gnt(coll_gnt), .store_gnt(store_gnt), .disp_gnt(disp_gnt),
      .wr_addr(wr_addr), .hazard_stall(hazard_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      {load_req, coll_req, store_req, disp_req} = '0;
      {load_addr, coll_addr, store_addr, disp_addr0, disp_addr1} = '0;
      step(2);
      rst = 1'b1;
   endtask

   // packs grants as {load, coll, store, disp}
   function automatic logic [3:0] gnts();
      return {load_gnt, coll_gnt, store_gnt, disp_gnt};
   endfunction

   initial begin
      do_reset();
      chk("rst_gnt", gnts(), 4'b0000);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_hazard", hazard_stall, 0);
      // 1: single loader transfer, address lock, turnaround
      load_req = 1; load_addr = 3'd2;
      step();
      chk("t1_gnt", gnts(), 4'b1000);
      chk("t1_wr_addr", wr_addr, 2);
      load_addr = 3'd6;
      step(3);
      chk("t1_addr_locked", wr_addr, 2);
      load_req = 0;
      step();
      chk("t1_release", gnts(), 4'b0000);
      chk("t1_wr_addr_idle", wr_addr, 0);
      load_req = 1;
      step();
      chk("t1_regrant", gnts(), 4'b1000);
      chk("t1_regrant_addr", wr_addr, 6);
      // 2: write-port round robin with dead cycle
      do_reset();
      load_req = 1; coll_req = 1; load_addr = 3'd1; coll_addr = 3'd2;
      step();
      chk("t2_first_load", gnts(), 4'b1000);
      step(3);
      load_req = 0;
      step();
      chk("t2_dead1", gnts(), 4'b0000);
      load_req = 1;
      step();
      chk("t2_then_coll", gnts(), 4'b0100);
      chk("t2_coll_addr", wr_addr, 2);
      step(3);
      coll_req = 0;
      step();
      chk("t2_dead2", gnts(), 4'b0000);
      coll_req = 1;
      step();
      chk("t2_then_load", gnts(), 4'b1000);
      // 3: dispatcher blocked by collector owning addr 3
      do_reset();
      coll_req = 1; coll_addr = 3'd3;
      step();
      chk("t3_coll", gnts(), 4'b0100);
      disp_req = 1; disp_addr0 = 3'd1; disp_addr1 = 3'd3;
      #1;
      chk("t3_stall_comb", hazard_stall, 1);
      step();
      chk("t3_blocked", gnts(), 4'b0100);
      chk("t3_stall", hazard_stall, 1);
      coll_req = 0;
      step();
      chk("t3_coll_rel", gnts(), 4'b0000);
      step();
      chk("t3_disp", gnts(), 4'b0001);
      chk("t3_stall_clear", hazard_stall, 0);
      // 4: same-cycle same-address read and write, read wins
      do_reset();
      store_req = 1; store_addr = 3'd4; load_req = 1; load_addr = 3'd4;
      #1;
      chk("t4_stall_comb", hazard_stall, 1);
      step();
      chk("t4_store", gnts(), 4'b0010);
      chk("t4_stall", hazard_stall, 1);
      store_req = 0;
      step();
      chk("t4_store_rel", gnts(), 4'b0000);
      step();
      chk("t4_load", gnts(), 4'b1000);
      chk("t4_wr_addr", wr_addr, 4);
      // 5: distinct addresses, both ports granted together
      do_reset();
      store_req = 1; store_addr = 3'd0; coll_req = 1; coll_addr = 3'd5;
      step();
      chk("t5_both", gnts(), 4'b0110);
      chk("t5_wr_addr", wr_addr, 5);
      chk("t5_stall", hazard_stall, 0);
      // read-port pointer starts at the dispatcher
      do_reset();
      store_req = 1; store_addr = 3'd1; disp_req = 1; disp_addr0 = 3'd2; disp_addr1 = 3'd3;
      step();
      chk("rr_read_disp", gnts(), 4'b0001);
      // 6: asynchronous reset during a dispatcher grant
      rst = 0;
      #1;
      chk("t6_async_drop", gnts(), 4'b0000);
      store_req = 0; disp_req = 0;
      step();
      rst = 1;
      step(2);
      chk("t6_idle", gnts(), 4'b0000);
      disp_req = 1;
      step();
      chk("t6_new_req", gnts(), 4'b0001);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
